// File: rtl/adc_run_counter_if.sv
//-----------------------------------------------------------------------------
// adc_run_counter_if : ADC handshake, sample data and run-count result bundle
// Rev 1.0
//-----------------------------------------------------------------------------
`default_nettype none

interface adc_run_counter_if #(
  parameter int W  = 8,
  parameter int OW = 3
);
  logic          eoc;
  logic [W-1:0]  x;
  logic          mode;
  logic          soc;
  logic [OW-1:0] out;

  modport master (output eoc, output x, output mode, input soc, input out);
  modport slave  (input eoc, input x, input mode, output soc, output out);
endinterface

`default_nettype wire

// File: rtl/adc_run_counter.sv
//-----------------------------------------------------------------------------
// adc_run_counter : captures one ADC sample, counts runs >= MINRUN of a bit value
// Rev 1.0
//-----------------------------------------------------------------------------
`default_nettype none

module adc_run_counter #(
  parameter int W      = 8,
  parameter int MINRUN = 2,
  parameter int OW     = 3,
  parameter int HOLD   = 20
) (
  input  wire logic         clock,
  input  wire logic         reset_,
  adc_run_counter_if.slave  bus
);

  localparam int c_cnt_w  = $clog2(W + 1);
  localparam int c_rl_w   = $clog2(MINRUN + 1);
  localparam int c_wait_w = $clog2(HOLD + 1);

  localparam logic [c_cnt_w-1:0]  c_cnt_init  = c_cnt_w'(W);
  localparam logic [c_cnt_w-1:0]  c_cnt_last  = c_cnt_w'(1);
  localparam logic [c_rl_w-1:0]   c_rl_hit    = c_rl_w'(MINRUN - 1);
  localparam logic [c_rl_w-1:0]   c_rl_max    = c_rl_w'(MINRUN);
  localparam logic [c_wait_w-1:0] c_wait_init = c_wait_w'(HOLD);
  localparam logic [c_wait_w-1:0] c_wait_last = c_wait_w'(1);
  localparam logic [OW-1:0]       c_n_max     = {OW{1'b1}};

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CAPT = 3'd1,
    ST_SCAN = 3'd2,
    ST_UPD  = 3'd3,
    ST_HOLD = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic                soc_q, soc_d;
  logic [OW-1:0]       out_q, out_d;
  logic [OW-1:0]       n_q, n_d;
  logic [c_rl_w-1:0]   rl_q, rl_d;
  logic [W-1:0]        buf_q, buf_d;
  logic                mode_q, mode_d;
  logic [c_cnt_w-1:0]  cnt_q, cnt_d;
  logic [c_wait_w-1:0] wait_q, wait_d;
  logic                scan_bit;

  always_comb begin
    state_d  = state_q;
    soc_d    = soc_q;
    out_d    = out_q;
    n_d      = n_q;
    rl_d     = rl_q;
    buf_d    = buf_q;
    mode_d   = mode_q;
    cnt_d    = cnt_q;
    wait_d   = wait_q;
    scan_bit = buf_q[0];

    case (state_q)
      ST_IDLE: begin
        soc_d = 1'b1;
        if (!bus.eoc) state_d = ST_CAPT;
      end
      ST_CAPT: begin
        soc_d  = 1'b0;
        buf_d  = bus.x;
        mode_d = bus.mode;
        n_d    = '0;
        rl_d   = '0;
        cnt_d  = c_cnt_init;
        if (bus.eoc) state_d = ST_SCAN;
      end
      ST_SCAN: begin
        // Fill with the non-matching value so shifted-in bits never extend a run
        buf_d = {~mode_q, buf_q[W-1:1]};
        if (scan_bit == mode_q && rl_q == c_rl_hit) begin
          if (n_q != c_n_max) n_d = n_q + 1'b1;
          rl_d = c_rl_max;
        end else if (scan_bit == mode_q) begin
          if (rl_q < c_rl_max) rl_d = rl_q + 1'b1;
        end else begin
          rl_d = '0;
        end
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == c_cnt_last) state_d = ST_UPD;
      end
      ST_UPD: begin
        out_d   = n_q;
        wait_d  = c_wait_init;
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        wait_d = wait_q - 1'b1;
        if (wait_q == c_wait_last) begin
          soc_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        soc_d   = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    n_q    <= n_d;
    rl_q   <= rl_d;
    buf_q  <= buf_d;
    mode_q <= mode_d;
    cnt_q  <= cnt_d;
    wait_q <= wait_d;
    if (!reset_) begin
      state_q <= ST_IDLE;
      soc_q   <= 1'b1;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      soc_q   <= soc_d;
      out_q   <= out_d;
    end
  end

  assign bus.soc = soc_q;
  assign bus.out = out_q;

endmodule

`default_nettype wire
